// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate format codes and per-result metadata
// for the pipelined immediate generator.
package imm_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } imm_fmt_e;

  // Width-independent part of a result; imm and tag widths are module
  // parameters, so the full result struct is declared in the top.
  typedef struct packed {
    imm_fmt_e fmt;
    logic     illegal;
  } imm_meta_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32/RV64 immediate decoder: instruction word to
// extended immediate, format code and illegal-opcode flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode: XLEN must be 32 or 64");
  end

  logic [6:0] w_opc;
  logic [2:0] w_f3;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];

  always_comb begin
    o_imm     = '0;
    o_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC: begin
        o_imm = XLEN'($signed({i_instr[31:12], 12'b0}));
        o_fmt = FMT_U;
      end
      OPC_JAL: begin
        o_imm = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                               i_instr[30:21], 1'b0}));
        o_fmt = FMT_J;
      end
      OPC_JALR, OPC_LOAD: begin
        o_imm = XLEN'($signed(i_instr[31:20]));
        o_fmt = FMT_I;
      end
      OPC_OPIMM: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          // Shift amount only; funct7 (incl. the SRAI bit 30) is excluded.
          if (XLEN == 64) o_imm = XLEN'(i_instr[25:20]);
          else            o_imm = XLEN'(i_instr[24:20]);
          o_fmt = FMT_SHAMT;
        end else begin
          o_imm = XLEN'($signed(i_instr[31:20]));
          o_fmt = FMT_I;
        end
      end
      OPC_BRANCH: begin
        o_imm = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                               i_instr[11:8], 1'b0}));
        o_fmt = FMT_B;
      end
      OPC_STORE: begin
        o_imm = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
        o_fmt = FMT_S;
      end
      OPC_SYSTEM: begin
        if (w_f3[2]) begin
          o_imm = XLEN'(i_instr[19:15]);
          o_fmt = FMT_ZIMM;
        end else begin
          o_imm = XLEN'($signed(i_instr[31:20]));
          o_fmt = FMT_I;
        end
      end
      OPC_OP, OPC_FENCE: begin
        o_fmt = FMT_NONE;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: one-cycle decode into an output register
// backed by a single skid entry, valid/ready on both sides.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_meta_t        meta;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_illegal;
  res_t            w_new;
  logic            w_acc;
  logic            w_main_free;

  res_t r_main;
  res_t r_skid;
  logic r_main_vld;
  logic r_skid_vld;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .i_instr  (in_instr),
    .o_imm    (w_imm),
    .o_fmt    (w_fmt),
    .o_illegal(w_illegal)
  );

  always_comb begin
    w_new              = '0;
    w_new.imm          = w_imm;
    w_new.meta.fmt     = imm_fmt_e'(w_fmt);
    w_new.meta.illegal = w_illegal;
    w_new.tag          = in_tag;
  end

  // in_ready comes straight from the skid-valid flop, so it is registered.
  assign in_ready    = ~r_skid_vld;
  assign w_acc       = in_valid & ~r_skid_vld;
  assign w_main_free = ~r_main_vld | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (w_main_free) begin
      // Skid can only be full when in_ready is low, so no accept competes.
      if (r_skid_vld) begin
        r_main     <= r_skid;
        r_main_vld <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_acc) begin
        r_main     <= w_new;
        r_main_vld <= 1'b1;
      end else begin
        r_main_vld <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid     <= w_new;
      r_skid_vld <= 1'b1;
    end
  end

  assign out_valid   = r_main_vld;
  assign out_imm     = r_main.imm;
  assign out_fmt     = r_main.meta.fmt;
  assign out_illegal = r_main.meta.illegal;
  assign out_tag     = r_main.tag;

endmodule
